// File: rtl/video_dram_arb_if.sv
// Bundles the slot strobe, video fetch, CPU access and DRAM slot signals of the arbiter.
// Pure wiring, no latency of its own.
// No backpressure: the slot strobe paces all traffic, and the next/strobe pulses act as acknowledgements.
interface video_dram_arb_if;
  logic        dram_stb;
  logic        frame_start;
  logic        video_go;
  logic [20:0] video_addr;
  logic [4:0]  video_bw;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [20:0] cpu_addr;
  logic [15:0] cpu_wrdata;
  logic [1:0]  cpu_wrbsel;
  logic [15:0] dram_rddata;
  logic        dram_req;
  logic        dram_rnw;
  logic [20:0] dram_addr;
  logic [15:0] dram_wrdata;
  logic [1:0]  dram_bsel;
  logic        video_next;
  logic        video_strobe;
  logic [15:0] video_data;
  logic        cpu_next;
  logic        cpu_strobe;
  logic [15:0] cpu_rddata;

  // Arbiter side
  modport slave (
    input  dram_stb, frame_start, video_go, video_addr, video_bw,
           cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel, dram_rddata,
    output dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel,
           video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rddata
  );

  // Requester / DRAM-controller side
  modport master (
    output dram_stb, frame_start, video_go, video_addr, video_bw,
           cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel, dram_rddata,
    input  dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel,
           video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rddata
  );
endinterface

// File: rtl/video_dram_arb.sv
// Assigns each DRAM slot to video fetch, CPU read/write or idle, and routes read data back.
// Latency: grant pulses 1 clk after the deciding dram_stb; read data strobes 1 slot + 1 clk after it.
// No backpressure: video always owns its slots; the CPU holds cpu_req until it sees cpu_next.
module video_dram_arb (
  input  logic               clk,
  input  logic               rst_n,
  video_dram_arb_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} owner_e;

  owner_e      owner_q, owner_d;
  logic [2:0]  sc_q;
  logic [2:0]  sc_cur;
  logic [2:0]  pos;
  logic [2:0]  need;
  logic        vid_slot;

  logic        dram_req_q, dram_rnw_q;
  logic [20:0] dram_addr_q;
  logic [15:0] dram_wrdata_q;
  logic [1:0]  dram_bsel_q;
  logic        video_next_q, video_strobe_q, cpu_next_q, cpu_strobe_q;
  logic [15:0] video_data_q, cpu_rddata_q;

  // Slot position within the video period and the number of slots video needs.
  // frame_start forces the current slot to be treated as slot 0.
  always_comb begin
    sc_cur = bus.frame_start ? 3'd0 : sc_q;
    case (bus.video_bw[4:3])
      2'b00:   pos = {2'b00, sc_cur[0]};
      2'b01:   pos = {1'b0, sc_cur[1:0]};
      default: pos = sc_cur;
    endcase
    if (bus.video_bw[2])      need = 3'd4;
    else if (bus.video_bw[1]) need = 3'd2;
    else if (bus.video_bw[0]) need = 3'd1;
    else                      need = 3'd0;
    // pos never reaches the period, so need >= period makes every slot a video slot
    vid_slot = bus.video_go && (pos < need);
  end

  // Slot counter: advances per strobe, resynchronised by frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sc_q <= 3'd0;
    else if (bus.frame_start)  sc_q <= bus.dram_stb ? 3'd1 : 3'd0;
    else if (bus.dram_stb)     sc_q <= sc_q + 3'd1;
  end

  // Owner state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= IDLE;
    else        owner_q <= owner_d;
  end

  // Owner decision, taken only on a slot strobe; video has priority over the CPU.
  always_comb begin
    owner_d = owner_q;
    if (bus.dram_stb) begin
      if (vid_slot)         owner_d = VID;
      else if (bus.cpu_req) owner_d = bus.cpu_rnw ? CPU_RD : CPU_WR;
      else                  owner_d = IDLE;
    end
  end

  // Slot outputs, grant pulses and read-data return, all captured on the slot strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_req_q     <= 1'b0;
      dram_rnw_q     <= 1'b0;
      dram_addr_q    <= '0;
      dram_wrdata_q  <= '0;
      dram_bsel_q    <= '0;
      video_next_q   <= 1'b0;
      video_strobe_q <= 1'b0;
      video_data_q   <= '0;
      cpu_next_q     <= 1'b0;
      cpu_strobe_q   <= 1'b0;
      cpu_rddata_q   <= '0;
    end else begin
      video_next_q   <= 1'b0;
      video_strobe_q <= 1'b0;
      cpu_next_q     <= 1'b0;
      cpu_strobe_q   <= 1'b0;
      if (bus.dram_stb) begin
        // data for the slot that just ended arrives with this strobe
        if (owner_q == VID) begin
          video_data_q   <= bus.dram_rddata;
          video_strobe_q <= 1'b1;
        end
        if (owner_q == CPU_RD) begin
          cpu_rddata_q <= bus.dram_rddata;
          cpu_strobe_q <= 1'b1;
        end
        case (owner_d)
          VID: begin
            dram_req_q   <= 1'b1;
            dram_rnw_q   <= 1'b1;
            dram_addr_q  <= bus.video_addr;
            dram_bsel_q  <= 2'b11;
            video_next_q <= 1'b1;
          end
          CPU_RD: begin
            dram_req_q  <= 1'b1;
            dram_rnw_q  <= 1'b1;
            dram_addr_q <= bus.cpu_addr;
            dram_bsel_q <= 2'b11;
            cpu_next_q  <= 1'b1;
          end
          CPU_WR: begin
            dram_req_q    <= 1'b1;
            dram_rnw_q    <= 1'b0;
            dram_addr_q   <= bus.cpu_addr;
            dram_wrdata_q <= bus.cpu_wrdata;
            dram_bsel_q   <= bus.cpu_wrbsel;
            cpu_next_q    <= 1'b1;
          end
          default: dram_req_q <= 1'b0;
        endcase
      end
    end
  end

  assign bus.dram_req     = dram_req_q;
  assign bus.dram_rnw     = dram_rnw_q;
  assign bus.dram_addr    = dram_addr_q;
  assign bus.dram_wrdata  = dram_wrdata_q;
  assign bus.dram_bsel    = dram_bsel_q;
  assign bus.video_next   = video_next_q;
  assign bus.video_strobe = video_strobe_q;
  assign bus.video_data   = video_data_q;
  assign bus.cpu_next     = cpu_next_q;
  assign bus.cpu_strobe   = cpu_strobe_q;
  assign bus.cpu_rddata   = cpu_rddata_q;

endmodule

// File: doc/video_dram_arb.md
VIDEO_DRAM_ARB -- requirements
Module: video_dram_arb

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- dram_stb  in  1  one-clk pulse marking start of a DRAM slot
- frame_start  in  1  slot-counter resync pulse
- video_go  in  1  video fetch window active
- video_addr  in  21  video word address
- video_bw  in  5  [4:3] period (00=2, 01=4, 11=8, 10=8); [2:0] needed slots, one-hot (001=1, 010=2, 100=4)
- cpu_req  in  1  CPU access request
- cpu_rnw  in  1  1=read
- cpu_addr  in  21  CPU word address
- cpu_wrdata  in  16  CPU write data
- cpu_wrbsel  in  2  write byte enables
- dram_rddata  in  16  DRAM read data, valid in the clk of the next dram_stb
- dram_req  out  1  slot used
- dram_rnw  out  1  slot direction
- dram_addr  out  21  slot address
- dram_wrdata  out  16  slot write data
- dram_bsel  out  2  slot byte enables
- video_next  out  1  video address consumed
- video_strobe  out  1  video_data valid
- video_data  out  16  fetched video word
- cpu_next  out  1  CPU request consumed
- cpu_strobe  out  1  cpu_rddata valid
- cpu_rddata  out  16  CPU read word
REQ-002 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-003 A 3-bit slot counter sc SHALL increment (mod 8) on each clk with dram_stb=1.
REQ-004 frame_start=1 SHALL set sc to 0; with dram_stb in the same clk, that slot SHALL be decided with sc=0 and sc SHALL become 1.
REQ-005 Slot position pos SHALL be sc[0], sc[1:0] or sc[2:0] for periods 2, 4 and 8.
REQ-006 Need n SHALL be the highest set bit of video_bw[2:0] (1, 2 or 4); 000 SHALL give n=0.
REQ-007 A slot SHALL be a video slot iff video_go=1 and pos<n; n>=period SHALL make every slot a video slot.
REQ-008 On each dram_stb, the owner SHALL be VID for a video slot, otherwise CPU_RD or CPU_WR when cpu_req=1 (per cpu_rnw), otherwise IDLE.
REQ-009 Owner state SHALL be a registered state machine {IDLE, VID, CPU_RD, CPU_WR}, updated only on dram_stb and held between strobes.
REQ-010 dram_* outputs SHALL be registered on dram_stb and held for the whole slot:
- VID: req=1, rnw=1, addr=video_addr, bsel=11
- CPU_RD: req=1, rnw=1, addr=cpu_addr, bsel=11
- CPU_WR: req=1, rnw=0, addr=cpu_addr, wrdata=cpu_wrdata, bsel=cpu_wrbsel
- IDLE: req=0, other outputs hold
REQ-011 video_next (VID) or cpu_next (CPU_RD/CPU_WR) SHALL pulse for exactly one clk, in the clk after the deciding dram_stb.
REQ-012 On a dram_stb whose previous owner was VID, dram_rddata SHALL be latched into video_data, with video_strobe pulsing one clk later.
REQ-013 On a dram_stb whose previous owner was CPU_RD, dram_rddata SHALL be latched into cpu_rddata, with cpu_strobe pulsing one clk later.
REQ-014 IDLE and CPU_WR slots SHALL produce no strobe; video_data and cpu_rddata SHALL hold between strobes.
REQ-015 Read latency SHALL be exactly one slot plus one clk from the deciding dram_stb to the strobe.
REQ-016 Video SHALL always win its slots over CPU; cpu_req held across a video slot SHALL be granted at the first non-video slot.
REQ-017 frame_start SHALL NOT cancel a pending read return.
REQ-018 video_go falling mid-frame SHALL take effect at the next dram_stb; an in-flight video read SHALL still strobe.
REQ-019 Changes to video_bw or video_addr between strobes SHALL have no effect until the next dram_stb.

Reset
REQ-020 While rst_n=0: sc=0, owner=IDLE, and all outputs 0 (dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel, video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rddata).
REQ-021 Reset asserted mid-operation SHALL discard the pending read return, with no strobe after release.
REQ-022 The first dram_stb after release SHALL be decided with sc=0.

Verification
REQ-023 Scenario: video_bw=11_001, video_go=1, cpu_req=0, frame_start then 16 dram_stb -> dram_req=1 only for sc=0 and sc=0 (slots 0 and 8); two video_next and two video_strobe pulses.
REQ-024 Scenario: video_bw=11_100, cpu_req=1 constant, cpu_rnw=1, 8 dram_stb -> slots 0-3 VID and 4-7 CPU_RD; four video_next and four cpu_next pulses.
REQ-025 Scenario: VID slot with video_addr=0x12345; next dram_stb with dram_rddata=0xBEEF -> dram_addr=0x12345 during the slot; video_data=0xBEEF and video_strobe=1 one clk after the second dram_stb.
REQ-026 Scenario: CPU write (cpu_addr=0x00100, cpu_wrdata=0x55AA, cpu_wrbsel=01) in a non-video slot -> dram_rnw=0, dram_bsel=01, dram_wrdata=0x55AA, one cpu_next pulse, no cpu_strobe.
REQ-027 Scenario: video_bw=00_100 with cpu_req=1 for 10 slots -> every slot VID and no cpu_next; then video_go=0 -> cpu_next within one slot.
REQ-028 Scenario: rst_n pulsed low between a VID dram_stb and its return dram_stb -> all outputs 0 during reset, no video_strobe afterwards, and the next slot decided with sc=0.
